// File: rtl/aes_encrypt_iterative.sv
// Iterative AES encryptor: one full round per clock over a flat round-key vector
// supplied (and held stable) by the upstream key-expansion stage.
module aes_encrypt_iterative #(
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          plaintext,
    input  logic [128*(NR+1)-1:0] round_keys,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          ciphertext,
    output logic                  busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] NR_L = 4'(NR);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] t;
        t = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        return t;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        t = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            t[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            t[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            t[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            t[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return t;
    endfunction

    state_t       r_state;
    state_t       w_next_state;
    logic [127:0] r_sreg;
    logic [127:0] r_ct;
    logic [3:0]   r_rnd;
    logic [127:0] w_rk [0:NR];
    logic [127:0] w_rk_cur;
    logic [127:0] w_sub_shift;
    logic [127:0] w_round;
    logic         w_last;

    for (genvar g = 0; g <= NR; g++) begin : g_rk
        assign w_rk[g] = round_keys[128*(NR+1)-1-128*g -: 128];
    end

    assign w_rk_cur    = w_rk[r_rnd];
    assign w_last      = (r_rnd == NR_L);
    assign w_sub_shift = sub_shift(r_sreg);
    assign w_round     = (w_last ? w_sub_shift : mix_columns(w_sub_shift)) ^ w_rk_cur;
    assign ciphertext  = r_ct;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next_state = S_ROUND; else w_next_state = S_IDLE;
            S_ROUND: if (w_last)    w_next_state = S_DONE;  else w_next_state = S_ROUND;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;  else w_next_state = S_DONE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE:  in_ready = 1'b1;
            S_ROUND: busy     = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Round datapath: initial whitening on accept, one round per clock, result captured on last round
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg <= 128'h0;
            r_ct   <= 128'h0;
            r_rnd  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sreg <= plaintext ^ w_rk[0];
                        r_rnd  <= 4'd1;
                    end
                end
                S_ROUND: begin
                    r_sreg <= w_round;
                    if (w_last) begin
                        r_ct <= w_round;
                    end else begin
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_iterative.sv
// Bench for aes_encrypt_iterative: known-answer vectors with a scoreboard, plus
// stall, back-to-back, wider-key and mid-block reset sequences.
module tb_aes_encrypt_iterative;
    typedef struct {
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    typedef struct {
        logic [127:0] ct;
        int           acc;
    } sb_t;

    localparam logic [255:0] K128A = 256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
    localparam logic [255:0] K128B = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
    localparam logic [255:0] K192  = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0]  plaintext, ciphertext;
    logic [1407:0] rk10;
    logic          in_valid12, in_ready12, out_valid12, busy12;
    logic [127:0]  ct12;
    logic [1663:0] rk12;
    logic          in_valid14, in_ready14, out_valid14, busy14;
    logic [127:0]  ct14;
    logic [1919:0] rk14;

    logic [7:0]    tb_sbox [0:255];
    vec_t          vecs [0:6];
    sb_t           sb [$];
    int            acc_log [$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic [127:0]  drv_exp = 128'h0;
    logic          prev_ov = 1'b0;

    aes_encrypt_iterative #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .round_keys(rk10), .out_valid(out_valid),
        .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
    );

    aes_encrypt_iterative #(.NR(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid12), .in_ready(in_ready12),
        .plaintext(plaintext), .round_keys(rk12), .out_valid(out_valid12),
        .out_ready(out_ready), .ciphertext(ct12), .busy(busy12)
    );

    aes_encrypt_iterative #(.NR(14)) dut14 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid14), .in_ready(in_ready14),
        .plaintext(plaintext), .round_keys(rk14), .out_valid(out_valid14),
        .out_ready(out_ready), .ciphertext(ct14), .busy(busy14)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box derived from the GF(2^8) inverse plus affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            tb_sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                       ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
    endfunction

    // Key schedule; result left-justified, round key r at [1919-128*r -: 128]
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [0:59];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] res;
        int            nw;
        nw  = 4 * (nk + 7);
        rc  = 8'h01;
        res = '0;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nw; i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            res[1919-32*i -: 32] = w[i];
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] exp);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        plaintext = pt;
        drv_exp   = exp;
        in_valid  = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
        end
        check_int("accept", int'(got), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            done = (sb.size() == 0) && in_ready;
        end
        check_int("done_timeout", int'(done), 1);
    endtask

    // Scoreboard monitor: push on input handshake, compare/pop on output handshake
    always @(negedge clk) begin
        sb_t e;
        if (rst_n) begin
            if (in_valid && in_ready) begin
                e.ct  = drv_exp;
                e.acc = cyc + 1;
                sb.push_back(e);
                acc_log.push_back(cyc + 1);
            end
            if (out_valid && !prev_ov && sb.size() > 0)
                check_int("latency", cyc - sb[0].acc, 10);
            if (out_valid && out_ready) begin
                check_int("output_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    check("ciphertext", ciphertext, sb[0].ct);
                    void'(sb.pop_front());
                end
            end
        end
        prev_ov <= out_valid;
    end

    initial begin
        logic [1919:0] rk_all;
        logic [127:0]  got12, got14;
        int            a, lat12, lat14;
        bit            seen, seen12, seen14;

        vecs[0] = '{K128A, 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{K128B, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{256'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[3] = '{K128A, 128'h6bc1bee22e409f96e93d7e117393172a, 128'h3ad77bb40d7a3660a89ecaf32466ef97};
        vecs[4] = '{K128A, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'hf5d3d58503b9699de785895a96fdbaaf};
        vecs[5] = '{K128A, 128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'h43b1cd7f598ece23881b00e3ed030688};
        vecs[6] = '{K128A, 128'hf69f2445df4f9b17ad2b417be66c3710, 128'h7b0c785e27e8ad3f8223207104725dd4};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_valid12 = 1'b0;
        in_valid14 = 1'b0;
        out_ready  = 1'b1;
        plaintext  = 128'h0;
        rk10       = '0;
        rk12       = '0;
        rk14       = '0;
        build_sbox();

        repeat (2) @(posedge clk);
        #1;
        check_int("rst_in_ready", int'(in_ready), 1);
        check_int("rst_out_valid", int'(out_valid), 0);
        check_int("rst_busy", int'(busy), 0);
        check("rst_ciphertext", ciphertext, 128'h0);
        rst_n = 1'b1;

        // Known-answer table, one block at a time
        for (int i = 0; i < 7; i++) begin
            rk_all = expand(vecs[i].key, 4);
            rk10   = rk_all[1919 -: 1408];
            send(vecs[i].pt, vecs[i].ct);
            wait_done();
        end

        // Stall in DONE for 5 cycles with in_valid pulses
        rk_all    = expand(vecs[0].key, 4);
        rk10      = rk_all[1919 -: 1408];
        out_ready = 1'b0;
        send(vecs[0].pt, vecs[0].ct);
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check_int("stall_valid_seen", int'(seen), 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            in_valid  = (k % 2 == 0);
            plaintext = ~vecs[0].pt;
            @(negedge clk);
            check_int("stall_out_valid", int'(out_valid), 1);
            check_int("stall_in_ready", int'(in_ready), 0);
            check("stall_ciphertext", ciphertext, vecs[0].ct);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_done();
        repeat (2) @(negedge clk);
        check_int("stall_no_accept", int'(busy), 0);

        // Back-to-back with in_valid and out_ready held high
        acc_log.delete();
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            seen      = 1'b0;
            plaintext = vecs[3+k].pt;
            drv_exp   = vecs[3+k].ct;
            in_valid  = 1'b1;
            for (int j = 0; j < 40 && !seen; j++) begin
                @(negedge clk);
                seen = in_ready;
            end
            check_int("b2b_accept", int'(seen), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_done();
        check_int("b2b_count", acc_log.size(), 4);
        for (int k = 1; k < acc_log.size(); k++)
            check_int("b2b_spacing", acc_log[k] - acc_log[k-1], 12);

        // AES-192 and AES-256 instances started on the same edge
        rk_all    = expand(K192, 6);
        rk12      = rk_all[1919 -: 1664];
        rk14      = expand(K256, 8);
        plaintext = vecs[1].pt;
        @(posedge clk); #1;
        in_valid12 = 1'b1;
        in_valid14 = 1'b1;
        @(posedge clk); #1;
        a          = cyc;
        in_valid12 = 1'b0;
        in_valid14 = 1'b0;
        seen12 = 1'b0; seen14 = 1'b0; lat12 = -1; lat14 = -1;
        got12 = 128'h0; got14 = 128'h0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid12 && !seen12) begin seen12 = 1'b1; lat12 = cyc - a; got12 = ct12; end
            if (out_valid14 && !seen14) begin seen14 = 1'b1; lat14 = cyc - a; got14 = ct14; end
        end
        check_int("nr12_latency", lat12, 12);
        check_int("nr14_latency", lat14, 14);
        check("nr12_ciphertext", got12, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        check("nr14_ciphertext", got14, 128'h8ea2b7ca516745bfeafc49904b496089);
        check_int("nr14_idle_after", int'(in_ready14 && !busy14), 1);

        // Reset asserted with rnd=5
        rk_all = expand(vecs[0].key, 4);
        rk10   = rk_all[1919 -: 1408];
        send(vecs[0].pt, vecs[0].ct);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_int("abort_out_valid", int'(out_valid), 0);
        check("abort_ciphertext", ciphertext, 128'h0);
        check_int("abort_in_ready", int'(in_ready), 1);
        check_int("abort_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_int("abort_no_valid", int'(out_valid), 0);
        send(vecs[0].pt, vecs[0].ct);
        wait_done();
        check_int("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
